// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall sequencer.
// FSM state encoding and the hard-wired zero register index.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator.
// Flags an ID instruction that reads the destination of a load sitting in EX.
// Writes to x0 are discarded by the register file, so they never create a hazard.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  output logic       luse_o
);

  logic rs1_hit;
  logic rs2_hit;

  // Compare each used source operand against the pending load destination.
  always_comb begin
    rs1_hit = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    rs2_hit = id_use_rs2_i && (id_rs2_i == ex_rd_i);
    luse_o  = ex_memread_i && (ex_rd_i != REG_X0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Priority of responses: ERR > memory wait > redirect > load-use.
// Control outputs are combinational from the current state and inputs and are
// forced low while Rst is asserted. mem_err is the registered sticky timeout flag.
// Optional macro PIPE_HAZARD_CTRL_PERF_EN adds saturating stall/flush counters;
// without it stall_cnt/flush_cnt are constant 0 and no counter flops exist.
// dbg_state / dbg_wait_cnt expose the FSM state and watchdog count.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 255,
  parameter int CNT_W        = 8,
  parameter int PERF_W       = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_memread,
  input  logic [4:0]        ex_rd,
  input  logic              ex_redirect,
  input  logic              mem_req,
  input  logic              dmem_ready,
  output logic              pc_hold,
  output logic              if_id_hold,
  output logic              if_id_flush,
  output logic              id_ex_hold,
  output logic              id_ex_flush,
  output logic              ex_mem_hold,
  output logic              mem_wb_flush,
  output logic              mem_err,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt,
  output logic [1:0]        dbg_state,
  output logic [CNT_W-1:0]  dbg_wait_cnt
);

  localparam logic [CNT_W:0] TIMEOUT_C = (CNT_W+1)'(WAIT_TIMEOUT);

  state_e           state_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             mem_err_q;

  logic             luse;
  logic             in_err;
  logic             mem_wait;
  logic             redirect_apply;
  logic             luse_apply;
  logic [CNT_W:0]   cnt_nxt;

  hazard_detect u_hazard_detect (
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_use_rs1_i (id_use_rs1),
    .id_use_rs2_i (id_use_rs2),
    .ex_memread_i (ex_memread),
    .ex_rd_i      (ex_rd),
    .luse_o       (luse)
  );

  // Resolve which hazard response applies this cycle, by priority.
  always_comb begin
    in_err         = (state_q == ERR);
    mem_wait       = !in_err && mem_req && !dmem_ready;
    redirect_apply = !in_err && !mem_wait && ex_redirect;
    luse_apply     = !in_err && !mem_wait && !ex_redirect && luse;
    // The first wait cycle counts as 1; later ones extend the run.
    if (state_q == RUN) begin
      cnt_nxt = {{CNT_W{1'b0}}, 1'b1};
    end else begin
      cnt_nxt = {1'b0, wait_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    end
  end

  // Drive per-stage hold/flush controls from the selected response.
  always_comb begin
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_hold   = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_hold  = 1'b0;
    mem_wb_flush = 1'b0;
    if (!Rst) begin
      if (in_err || mem_wait) begin
        // Freeze everything up to EX_MEM and bubble MEM_WB.
        pc_hold      = 1'b1;
        if_id_hold   = 1'b1;
        id_ex_hold   = 1'b1;
        ex_mem_hold  = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (redirect_apply) begin
        // Squash the two wrong-path instructions behind the branch.
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (luse_apply) begin
        // Hold front end one cycle and insert a bubble into EX.
        pc_hold      = 1'b1;
        if_id_hold   = 1'b1;
        id_ex_flush  = 1'b1;
      end
    end
  end

  // Wait-state FSM with timeout watchdog and sticky error flag.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          if (mem_wait) begin
            wait_cnt_q <= cnt_nxt[CNT_W-1:0];
            if (cnt_nxt >= TIMEOUT_C) begin
              state_q   <= ERR;
              mem_err_q <= 1'b1;
            end else begin
              state_q   <= MEM_WAIT;
            end
          end else begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end
        end
        ERR: begin
          state_q <= ERR;
        end
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  assign mem_err      = mem_err_q;
  assign dbg_state    = state_q;
  assign dbg_wait_cnt = wait_cnt_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] flush_cnt_q;

  // Saturating counters of stalled cycles and applied redirects.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_hold && (stall_cnt_q != {PERF_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (redirect_apply && (flush_cnt_q != {PERF_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl (WAIT_TIMEOUT=4): directed vectors with
// literal expectations plus a rule-level model compared every negedge.
module tb_pipe_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 8;
  localparam int PW = 32;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_memread, ex_redirect, mem_req, dmem_ready;
  logic          pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
  logic          ex_mem_hold, mem_wb_flush, mem_err;
  logic [PW-1:0] stall_cnt, flush_cnt;
  logic [1:0]    dbg_state;
  logic [CW-1:0] dbg_wait_cnt;
  logic [6:0]    ctrl_vec;

  // order: pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, mem_wb_flush
  assign ctrl_vec = {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
                     ex_mem_hold, mem_wb_flush};

  pipe_hazard_ctrl #(.WAIT_TIMEOUT(TO), .CNT_W(CW), .PERF_W(PW)) dut (
    .Clk(Clk), .Rst(Rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_hold(id_ex_hold), .id_ex_flush(id_ex_flush), .ex_mem_hold(ex_mem_hold),
    .mem_wb_flush(mem_wb_flush), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks only "stuck in error" and "how many consecutive wait cycles so far".
  bit m_err;
  int m_consec;
  longint m_stall, m_flush;
  localparam longint PMAX = (64'd1 << PW) - 1;

  function automatic logic [6:0] exp_ctrl();
    logic hz;
    hz = ex_memread && (ex_rd != 5'd0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (Rst) return 7'b0000000;
    if (m_err) return 7'b1101011;
    if (mem_req && !dmem_ready) return 7'b1101011;
    if (ex_redirect) return 7'b0010100;
    if (hz) return 7'b1100100;
    return 7'b0000000;
  endfunction

  always @(posedge Clk or posedge Rst) begin
    logic [6:0] c;
    if (Rst) begin
      m_err = 1'b0; m_consec = 0; m_stall = 0; m_flush = 0;
    end else begin
      c = exp_ctrl();
      if (c[6] && m_stall != PMAX) m_stall++;
      if (!m_err && !(mem_req && !dmem_ready) && ex_redirect && m_flush != PMAX) m_flush++;
      if (!m_err) begin
        if (mem_req && !dmem_ready) begin
          m_consec++;
          if (m_consec >= TO) m_err = 1'b1;
        end else begin
          m_consec = 0;
        end
      end
    end
  end

  // Compare process: every negedge outside reset.
  always @(negedge Clk) begin
    if (!Rst) begin
      chk("m_ctrl", {57'd0, ctrl_vec}, {57'd0, exp_ctrl()});
      chk("m_mem_err", {63'd0, mem_err}, {63'd0, m_err});
      chk("m_state", {62'd0, dbg_state}, m_err ? 64'd2 : (m_consec > 0 ? 64'd1 : 64'd0));
      chk("m_wait_cnt", {56'd0, dbg_wait_cnt}, 64'(m_consec));
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      chk("m_stall_cnt", {32'd0, stall_cnt}, 64'(m_stall));
      chk("m_flush_cnt", {32'd0, flush_cnt}, 64'(m_flush));
`else
      chk("m_stall_cnt", {32'd0, stall_cnt}, 64'd0);
      chk("m_flush_cnt", {32'd0, flush_cnt}, 64'd0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic nxt();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic mr, input logic [4:0] rd,
                       input logic redir, input logic mreq, input logic rdy);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_memread = mr; ex_rd = rd; ex_redirect = redir; mem_req = mreq; dmem_ready = rdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // Each step: drive at posedge+1, literal checks at posedge+3, advance.
  task automatic step_chk(input string name, input logic [6:0] exp);
    #2;
    chk(name, {57'd0, ctrl_vec}, {57'd0, exp});
    nxt();
  endtask

  // Safety net: the directed flow is bounded, but never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    Rst = 1'b1;
    idle();
    #3;
    chk("rst_ctrl", {57'd0, ctrl_vec}, 64'd0);
    chk("rst_state", {62'd0, dbg_state}, 64'd0);
    chk("rst_wait_cnt", {56'd0, dbg_wait_cnt}, 64'd0);
    chk("rst_mem_err", {63'd0, mem_err}, 64'd0);
    chk("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
    chk("rst_flush_cnt", {32'd0, flush_cnt}, 64'd0);
    nxt();
    Rst = 1'b0;
    nxt();

    // Load-use on rs2: one-cycle bubble, then idle.
    drive(5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    step_chk("luse_rs2", 7'b1100100);
    idle();
    step_chk("luse_after", 7'b0000000);
    // Same but destination x0: no stall.
    drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    step_chk("luse_x0", 7'b0000000);
    // Redirect together with load-use: flush wins.
    drive(5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
    step_chk("redir_luse", 7'b0010100);
    // Plain redirect.
    idle(); ex_redirect = 1'b1;
    step_chk("redir", 7'b0010100);
    // Memory wait for 3 cycles, then ready.
    idle(); mem_req = 1'b1; dmem_ready = 1'b0;
    step_chk("wait1", 7'b1101011);
    step_chk("wait2", 7'b1101011);
    #2; chk("wait3_state", {62'd0, dbg_state}, 64'd1);
    chk("wait3_cnt", {56'd0, dbg_wait_cnt}, 64'd2);
    step_chk("wait3", 7'b1101011);
    dmem_ready = 1'b1;
    step_chk("wait_done", 7'b0000000);
    idle();
    #2; chk("wait_run_state", {62'd0, dbg_state}, 64'd0);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    chk("perf_stall", {32'd0, stall_cnt}, 64'd4);
    chk("perf_flush", {32'd0, flush_cnt}, 64'd2);
`else
    chk("perf_stall", {32'd0, stall_cnt}, 64'd0);
    chk("perf_flush", {32'd0, flush_cnt}, 64'd0);
`endif
    nxt();

    // Load-use on rs1, non-load in EX, zero-wait access, ready-cycle with load-use.
    drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
    step_chk("luse_rs1", 7'b1100100);
    drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b1);
    step_chk("no_load", 7'b0000000);
    drive(5'd7, 5'd3, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1);
    step_chk("zero_wait", 7'b0000000);
    drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
    step_chk("wait_over_redir", 7'b1101011);
    dmem_ready = 1'b1; ex_redirect = 1'b0;
    step_chk("ready_luse", 7'b1100100);
    idle();
    nxt();

    // Timeout: 4 wait cycles then ERR, sticky after mem_req drops.
    idle(); mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < TO; i++) step_chk("to_wait", 7'b1101011);
    #2;
    chk("to_state", {62'd0, dbg_state}, 64'd2);
    chk("to_mem_err", {63'd0, mem_err}, 64'd1);
    nxt();
    idle(); ex_redirect = 1'b1;
    #2;
    chk("err_sticky_ctrl", {57'd0, ctrl_vec}, 64'h6B);
    chk("err_sticky_flag", {63'd0, mem_err}, 64'd1);
    nxt();
    idle();
    #1; Rst = 1'b1; #1;
    chk("err_rst_ctrl", {57'd0, ctrl_vec}, 64'd0);
    chk("err_rst_flag", {63'd0, mem_err}, 64'd0);
    chk("err_rst_state", {62'd0, dbg_state}, 64'd0);
    #1; Rst = 1'b0;
    nxt();

    // Reset pulsed in the 2nd MEM_WAIT cycle.
    mem_req = 1'b1; dmem_ready = 1'b0;
    nxt();
    nxt();
    #1;
    chk("mw_pre_state", {62'd0, dbg_state}, 64'd1);
    Rst = 1'b1; #1;
    chk("mw_rst_ctrl", {57'd0, ctrl_vec}, 64'd0);
    chk("mw_rst_state", {62'd0, dbg_state}, 64'd0);
    chk("mw_rst_cnt", {56'd0, dbg_wait_cnt}, 64'd0);
    chk("mw_rst_flag", {63'd0, mem_err}, 64'd0);
    #1; Rst = 1'b0;
    idle();
    nxt();
    nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (PC, IF_ID, ID_EX, EX_MEM, MEM_WB registers).
- Detects load-use hazards and taken branches/jumps, and freezes the pipe while the data memory is not ready.
- Drives the per-stage hold and flush inputs of every pipeline register.
- Contains a wait-state FSM with a timeout watchdog for data-memory accesses.

Parameters:
- WAIT_TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before entering ERR.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > WAIT_TIMEOUT.
- PERF_W, 32, width of the performance counters (optional feature only).

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_memread  in  1  EX instruction is a load.
- ex_rd  in  5  destination register of the EX instruction.
- ex_redirect  in  1  taken branch or jump resolved in EX.
- mem_req  in  1  MEM instruction accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_hold  out  1  PC keeps its value.
- if_id_hold  out  1  IF_ID keeps its contents.
- if_id_flush  out  1  IF_ID is cleared.
- id_ex_hold  out  1  ID_EX keeps its contents.
- id_ex_flush  out  1  ID_EX loads a bubble.
- ex_mem_hold  out  1  EX_MEM keeps its contents.
- mem_wb_flush  out  1  MEM_WB loads a bubble.
- mem_err  out  1  sticky data-memory timeout flag.
- stall_cnt  out  PERF_W  stall-cycle count (optional feature).
- flush_cnt  out  PERF_W  redirect-flush count (optional feature).

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. Reset enters RUN, clears wait_cnt and mem_err, and zeroes stall_cnt and flush_cnt.
- All control outputs are combinational from the current state and current inputs; in RUN with no hazard they are all 0.
- Memory-wait condition: mem_req=1 and dmem_ready=0, evaluated in RUN or MEM_WAIT.
  - Response: pc_hold, if_id_hold, id_ex_hold and ex_mem_hold are 1; mem_wb_flush is 1.
  - All other outputs are 0. ex_redirect and load-use are ignored.
- RUN to MEM_WAIT: on the memory-wait condition. wait_cnt is loaded with 1.
- MEM_WAIT while dmem_ready=0: wait_cnt increments.
- MEM_WAIT to ERR: when wait_cnt reaches WAIT_TIMEOUT with dmem_ready still 0; mem_err is set.
- MEM_WAIT to RUN: when dmem_ready=1. In that cycle there is no freeze and the MEM result passes to MEM_WB.
- The dmem_ready=1 cycle is evaluated as RUN for redirect and load-use, so those apply in the same cycle.
- ERR: all holds are 1, mem_wb_flush is 1, and mem_err is 1. Only Rst exits this state.
- Redirect (RUN, no memory wait, ex_redirect=1): if_id_flush=1 and id_ex_flush=1; holds are 0. Load-use is suppressed because the ID instruction is squashed.
- Load-use (RUN, no memory wait, no redirect): condition is ex_memread=1, ex_rd!=0, and ((id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd)).
  - Response: pc_hold=1, if_id_hold=1, id_ex_flush=1. This is a 1-cycle bubble.
- Priority: ERR > memory wait > redirect > load-use.
- An x0 destination never triggers load-use.
- mem_req=1 with dmem_ready=1 in RUN is a zero-wait access and produces no stall.
- Rst asserted mid-wait returns the FSM to RUN immediately (asynchronous) and clears all outputs.

Optional Feature:
- Macro: PIPE_HAZARD_CTRL_PERF_EN.
- When defined:
  - stall_cnt increments on each cycle with pc_hold=1.
  - flush_cnt increments on each cycle with ex_redirect applied.
  - Both counters saturate at all-ones and are cleared by Rst.
- When undefined: stall_cnt and flush_cnt are driven to constant 0 and no counter flops are generated.

Decomposition:
- Shared package pipe_ctrl_pkg holds the FSM state enum (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2) and the register-index constant REG_X0=5'd0.
- One sub-module, hazard_detect: purely combinational load-use comparator producing luse.
- The FSM, the watchdog and the counters stay in the top module.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 → for 1 cycle pc_hold=1, if_id_hold=1, id_ex_flush=1; then all outputs 0. Repeat with ex_rd=0 → no stall.
- Redirect plus load-use: ex_redirect=1 with the load-use condition also true → if_id_flush=1, id_ex_flush=1, pc_hold=0.
- Memory wait: mem_req=1 with dmem_ready=0 for 3 cycles, then 1 → holds and mem_wb_flush=1 for exactly 3 cycles; the 4th cycle has holds=0 and the FSM is in RUN.
- Timeout: WAIT_TIMEOUT=4, dmem_ready held 0 → ERR after 4 wait cycles, mem_err=1, freeze persists; dropping mem_req does not clear it. Rst clears it.
- Reset mid-wait: Rst pulsed in the 2nd MEM_WAIT cycle → all outputs 0 asynchronously, state RUN, wait_cnt 0.
- Perf counters (PIPE_HAZARD_CTRL_PERF_EN defined): 1 load-use + 3 wait cycles + 2 redirects → stall_cnt=4, flush_cnt=2. Without the macro both read 0.
